bram_pipelined: RTL and testbench
=================================

// Module: bram_pipelined
// PURPOSE
//   Simple dual-port block RAM for the max-pooling datapath, next generation of the single-cycle BRAM.
//   Adds arbitrary DEPTH, byte-lane write enables, configurable read latency with a read-valid strobe,
//   selectable read-during-write mode and out-of-range address detection. Buffers feature-map rows.
// PARAMETERS
//   DEPTH         16  number of words, any value >= 2 (not restricted to powers of two)
//   DATA_WIDTH    32  word width in bits; must be a multiple of LANE_WIDTH
//   LANE_WIDTH     8  bits per write-enable lane; NLANES = DATA_WIDTH/LANE_WIDTH
//   READ_LATENCY   2  cycles from accepted rd_en to rd_valid, legal range 1..4
//   RDW_MODE       0  same-address read/write in one cycle: 0 = old data, 1 = new (merged) data
//   ADDR_WIDTH = $clog2(DEPTH), derived localparam, not overridable
// PORTS
//   clk       in   1           clock; all logic on rising edge
//   rst_n     in   1           synchronous reset, active-low
//   wr_en     in   1           write request
//   wr_addr   in   ADDR_WIDTH  write address
//   wr_data   in   DATA_WIDTH  write data
//   wr_be     in   NLANES      per-lane write enable, bit i covers wr_data[i*LANE_WIDTH +: LANE_WIDTH]
//   rd_en     in   1           read request
//   rd_addr   in   ADDR_WIDTH  read address
//   rd_data   out  DATA_WIDTH  read data, valid when rd_valid
//   rd_valid  out  1           one-cycle strobe per accepted read
//   addr_err  out  1           one-cycle pulse: an accepted access in the previous cycle had address >= DEPTH
//   busy      out  1           1 = accesses ignored (clear in progress); constant 0 without macro
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): rd_data=0, rd_valid=0, addr_err=0, all read-pipeline valids cleared;
//     in-flight reads are dropped. Array contents are not touched by reset (see CONFIGURATION).
//   Accept: an access is accepted only when busy=0; requests made while busy=1 are discarded.
//   Write: accepted wr_en with wr_addr<DEPTH updates only lanes with wr_be[i]=1; wr_be=0 is a no-op.
//   Read: accepted rd_en samples rd_addr; rd_data/rd_valid appear exactly READ_LATENCY cycles later.
//     Fully pipelined, one read per cycle, back-to-back reads give back-to-back rd_valid.
//     rd_data holds its last value while rd_valid=0.
//   Out of range (addr >= DEPTH): write is dropped; read returns 0 with rd_valid still asserted;
//     addr_err=1 in the cycle after acceptance (single pulse even if both ports are out of range).
//   Read-during-write, same address, same cycle: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns
//     the written lanes merged with the old unwritten lanes. Different addresses are independent.
//   Writes reach the array in 1 cycle; a read accepted the cycle after a write sees the new data.
// CONFIGURATION
//   BRAM_INIT_CLEAR_EN defined: two-state FSM CLEAR -> READY. Reset forces CLEAR with counter=0,
//     busy=1; each cycle writes 0 to address counter and increments it; after writing DEPTH-1 the FSM
//     moves to READY, busy=0. busy is high for exactly DEPTH cycles after rst_n rises. Reset during
//     CLEAR restarts at address 0. READY is held until the next reset.
//   Not defined: no FSM, no counter; busy tied 0; array contents are undefined until written.
// TESTING (defaults unless stated)
//   1 Write 0xDEADBEEF @3 (wr_be=4'hF), then write 0x000000AA @3 wr_be=4'h1, read @3 -> rd_valid
//     exactly 2 cycles after rd_en, rd_data=0xDEADBEAA.
//   2 Reads @0..15 on 16 consecutive cycles after filling mem[i]=i*0x01010101 -> 16 consecutive
//     rd_valid cycles with matching data in order; repeat with READ_LATENCY=1 and 4.
//   3 Same-cycle write 0x11111111 and read @5 (old 0x55555555): RDW_MODE=0 -> 0x55555555;
//     RDW_MODE=1 -> 0x11111111; with wr_be=4'h3 and RDW_MODE=1 -> 0x55551111.
//   4 DEPTH=12: write @13 then read @13 -> addr_err pulses 1 cycle after each, rd_data=0, rd_valid=1,
//     no location 0..11 is modified.
//   5 Issue 2 reads, assert rst_n=0 for 1 cycle before their rd_valid -> no rd_valid, rd_data=0,
//     addr_err=0 after reset.
//   6 BRAM_INIT_CLEAR_EN, DEPTH=16: busy=1 for 16 cycles after reset, writes/reads then ignored;
//     afterwards reading all 16 addresses returns 0; reset at clear cycle 7 restarts the 16-cycle count.

Source files
------------

// File: rtl/bram_pipelined.sv
// Simple dual-port block RAM with byte-lane writes, pipelined reads and out-of-range detection.
// Optional power-up clear sequencer enabled by defining BRAM_INIT_CLEAR_EN.
module bram_pipelined #(
    parameter int DEPTH        = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int LANE_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int RDW_MODE     = 0,
    localparam int ADDR_WIDTH  = $clog2(DEPTH),
    localparam int NLANES      = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NLANES-1:0]     wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  addr_err,
    output logic                  busy
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_oor;
    logic                  rd_oor;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [READ_LATENCY-1:0] pv;
    logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

    assign wr_acc = wr_en & ~busy;
    assign rd_acc = rd_en & ~busy;
    assign wr_oor = {1'b0, wr_addr} >= DEPTH_W;
    assign rd_oor = {1'b0, rd_addr} >= DEPTH_W;

`ifdef BRAM_INIT_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    assign clr_we   = rst_n && (state == CLEAR);
    assign clr_addr = clr_cnt;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc && !wr_oor) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // New-data mode forwards the written lanes over the pre-write word on an address match.
    always_comb begin
        rd_word = '0;
        if (!rd_oor) begin
            rd_word = mem[rd_addr];
            if (RDW_MODE == 1 && wr_acc && !wr_oor && wr_addr == rd_addr) begin
                for (int unsigned i = 0; i < NLANES; i++) begin
                    if (wr_be[i]) begin
                        rd_word[i*LANE_WIDTH +: LANE_WIDTH] = wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv       <= '0;
            addr_err <= 1'b0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0]    <= rd_acc;
            addr_err <= (wr_acc & wr_oor) | (rd_acc & rd_oor);
            if (rd_acc) begin
                pd[0] <= rd_word;
            end
            // Data only advances with its valid so the last stage holds between reads.
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    assign rd_valid = pv[READ_LATENCY-1];
    assign rd_data  = pd[READ_LATENCY-1];

endmodule

// File: tb/tb_bram_pipelined.sv
// Directed bench for bram_pipelined: latency 1/2/4, both read-during-write modes and DEPTH=12.
// Adds clear-sequencer checks when BRAM_INIT_CLEAR_EN is defined.
module tb_bram_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic [31:0] d2, d1, d4, dr, dd;
    logic        v2, v1, v4, vr, vd;
    logic        e2, e1, e4, er, ed;
    logic        b2, b1, b4, br, bd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_pipelined u2 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d2), .rd_valid(v2), .addr_err(e2), .busy(b2));
    bram_pipelined #(.READ_LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1),
        .addr_err(e1), .busy(b1));
    bram_pipelined #(.READ_LATENCY(4)) u4 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d4), .rd_valid(v4),
        .addr_err(e4), .busy(b4));
    bram_pipelined #(.RDW_MODE(1)) ur (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dr), .rd_valid(vr),
        .addr_err(er), .busy(br));
    bram_pipelined #(.DEPTH(12)) ud (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dd), .rd_valid(vd),
        .addr_err(ed), .busy(bd));

    typedef struct {
        bit          we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          re;
        logic [3:0]  ra;
        bit          ev;
        logic [31:0] ed_old;
        logic [31:0] ed_new;
    } vec_t;

    vec_t tab [14];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be,
                         input bit re, input logic [3:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready;
        for (int n = 0; n < 64 && (b1 | b2 | b4 | br | bd); n++) tick;
        chk("busy_clear", {31'd0, b1 | b2 | b4 | br | bd}, 32'd0);
    endtask

    // Expected output of a latency-L instance after edge n of a read burst starting at edge 0.
    task automatic chk_lat(input string name, input int lat, input int n, input int nreads,
                           input logic v, input logic [31:0] d);
        int  src;
        bit  ev;
        src = n - lat + 1;
        ev  = (src >= 0) && (src < nreads);
        chk({name, "_valid"}, {31'd0, v}, {31'd0, ev});
        if (ev) chk({name, "_data"}, d, 32'(src) * 32'h01010101);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tab[0]  = '{1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 1'b0, 32'h0,        32'h0};
        tab[1]  = '{1'b1, 4'd3, 32'h000000AA, 4'h1, 1'b0, 4'd0, 1'b0, 32'h0,        32'h0};
        tab[2]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 1'b0, 32'h0,        32'h0};
        tab[3]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'hDEADBEAA, 32'hDEADBEAA};
        tab[4]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b0, 32'hDEADBEAA, 32'hDEADBEAA};
        tab[5]  = '{1'b1, 4'd5, 32'h55555555, 4'hF, 1'b0, 4'd0, 1'b0, 32'hDEADBEAA, 32'hDEADBEAA};
        tab[6]  = '{1'b1, 4'd5, 32'h11111111, 4'hF, 1'b1, 4'd5, 1'b0, 32'hDEADBEAA, 32'hDEADBEAA};
        tab[7]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'h55555555, 32'h11111111};
        tab[8]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5, 1'b0, 32'h55555555, 32'h11111111};
        tab[9]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'h11111111, 32'h11111111};
        tab[10] = '{1'b1, 4'd5, 32'h55555555, 4'hF, 1'b0, 4'd0, 1'b0, 32'h11111111, 32'h11111111};
        tab[11] = '{1'b1, 4'd5, 32'h11111111, 4'h3, 1'b1, 4'd5, 1'b0, 32'h11111111, 32'h11111111};
        tab[12] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b1, 32'h55555555, 32'h55551111};
        tab[13] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0, 1'b0, 32'h55555555, 32'h55551111};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        tick;
        chk("rst_valid", {31'd0, v2}, 32'd0);
        chk("rst_data", d2, 32'd0);
        chk("rst_err", {31'd0, e2}, 32'd0);
        chk("rst_data_l4", d4, 32'd0);
        rst_n = 1'b1;
        wait_ready;

        // Lane writes, latency, hold, and read-during-write in both modes.
        for (int i = 0; i < 14; i++) begin
            drive(tab[i].we, tab[i].wa, tab[i].wd, tab[i].be, tab[i].re, tab[i].ra);
            tick;
            chk($sformatf("tab%0d_valid", i), {31'd0, v2}, {31'd0, tab[i].ev});
            chk($sformatf("tab%0d_data", i), d2, tab[i].ed_old);
            chk($sformatf("tab%0d_err", i), {31'd0, e2}, 32'd0);
            chk($sformatf("tab%0d_rdw1_valid", i), {31'd0, vr}, {31'd0, tab[i].ev});
            chk($sformatf("tab%0d_rdw1_data", i), dr, tab[i].ed_new);
        end

        // Fill then back-to-back reads at latency 1, 2 and 4.
        for (int i = 0; i < 16; i++) begin
            drive(1, 4'(i), 32'(i) * 32'h01010101, 4'hF, 0, 0);
            tick;
        end
        for (int n = 0; n < 20; n++) begin
            drive(0, 0, 0, 0, n < 16, 4'(n));
            tick;
            chk_lat("burst_l1", 1, n, 16, v1, d1);
            chk_lat("burst_l2", 2, n, 16, v2, d2);
            chk_lat("burst_l4", 4, n, 16, v4, d4);
        end
        chk("hold_l1", d1, 32'h0F0F0F0F);
        chk("hold_l2", d2, 32'h0F0F0F0F);
        chk("hold_l4", d4, 32'h0F0F0F0F);

        // DEPTH=12 instance: out-of-range writes/reads.
        drive(1, 13, 32'hFFFFFFFF, 4'hF, 0, 0); tick;
        chk("oor_wr13_err", {31'd0, ed}, 32'd1);
        drive(0, 0, 0, 0, 0, 0); tick;
        chk("oor_wr13_err_end", {31'd0, ed}, 32'd0);
        drive(1, 12, 32'hFFFFFFFF, 4'hF, 0, 0); tick;
        chk("oor_wr12_err", {31'd0, ed}, 32'd1);
        for (int n = 0; n < 14; n++) begin
            drive(0, 0, 0, 0, n < 12, 4'(n));
            tick;
            chk_lat("d12_scan", 2, n, 12, vd, dd);
            chk("d12_scan_err", {31'd0, ed}, 32'd0);
        end
        drive(0, 0, 0, 0, 1, 13); tick;
        chk("oor_rd13_err", {31'd0, ed}, 32'd1);
        chk("oor_rd13_early", {31'd0, vd}, 32'd0);
        drive(0, 0, 0, 0, 0, 0); tick;
        chk("oor_rd13_err_end", {31'd0, ed}, 32'd0);
        chk("oor_rd13_valid", {31'd0, vd}, 32'd1);
        chk("oor_rd13_data", dd, 32'd0);
        drive(1, 13, 32'h12345678, 4'hF, 1, 14); tick;
        chk("oor_both_err", {31'd0, ed}, 32'd1);
        drive(0, 0, 0, 0, 0, 0); tick;
        chk("oor_both_err_end", {31'd0, ed}, 32'd0);
        chk("oor_rd14_valid", {31'd0, vd}, 32'd1);
        chk("oor_rd14_data", dd, 32'd0);
        tick;
        chk("oor_after_valid", {31'd0, vd}, 32'd0);
        chk("inr_err_u2", {31'd0, e2}, 32'd0);

        // Reset with reads in flight drops them.
        drive(0, 0, 0, 0, 1, 3); tick;
        drive(0, 0, 0, 0, 1, 5); tick;
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick;
        chk("midrst_valid_l4", {31'd0, v4}, 32'd0);
        chk("midrst_data_l4", d4, 32'd0);
        chk("midrst_data_l2", d2, 32'd0);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick;
            chk($sformatf("postrst%0d_valid_l4", n), {31'd0, v4}, 32'd0);
            chk($sformatf("postrst%0d_valid_l2", n), {31'd0, v2}, 32'd0);
            chk($sformatf("postrst%0d_data_l4", n), d4, 32'd0);
            chk($sformatf("postrst%0d_err_l4", n), {31'd0, e4}, 32'd0);
        end
        wait_ready;

`ifdef BRAM_INIT_CLEAR_EN
        begin
            int cnt;
            rst_n = 1'b0; tick; rst_n = 1'b1;
            drive(1, 0, 32'hFFFFFFFF, 4'hF, 1, 0);
            cnt = 0;
            while (b2 && cnt < 64) begin
                chk("clr_rd_ignored", {31'd0, v2}, 32'd0);
                cnt++;
                tick;
            end
            drive(0, 0, 0, 0, 0, 0);
            chk("clr_busy_cycles", 32'(cnt), 32'd16);
            for (int n = 0; n < 17; n++) begin
                drive(0, 0, 0, 0, n < 16, 4'(n));
                tick;
                if (n >= 1) begin
                    chk("clr_valid", {31'd0, v2}, 32'd1);
                    chk("clr_data", d2, 32'd0);
                end
            end
            rst_n = 1'b0; tick; rst_n = 1'b1;
            for (int n = 0; n < 7; n++) tick;
            rst_n = 1'b0; tick; rst_n = 1'b1;
            cnt = 0;
            while (b2 && cnt < 64) begin
                cnt++;
                tick;
            end
            chk("clr_restart_cycles", 32'(cnt), 32'd16);
            wait_ready;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
